noise_load_ctrl: RTL and testbench
==================================

Name: noise_load_ctrl

Overview:
- Sequencer in front of the 128-bin noise wrapper.
- On start, streams the noise distribution table from on-chip memory (OCM) into the wrapper: 64-bit words, each holding 8 signed 8-bit bins, default 16 words = 128 bins.
- Waits for the wrapper's done_wait, then gates the upstream sample stream into the wrapper.
- Owns reload, timeout and error signalling so the top level only pulses start.

Parameters:
- DATA_W, 64, table word width.
- ADDR_W, 8, OCM address and location width.
- NUM_ENTRIES, 16, maximum words per table load.
- MEM_LAT, 1, OCM read latency in cycles (1..4).
- TIMEOUT, 1024, maximum cycles in WAIT_DONE before error.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin table load; in RUN, reload.
- stop  in  1  one-cycle pulse: return to IDLE.
- cfg_len  in  ADDR_W  words to load; 0 means NUM_ENTRIES.
- ocm_rd_en  out  1  OCM read strobe.
- ocm_rd_addr  out  ADDR_W  OCM read address.
- ocm_rd_data  in  DATA_W  OCM read data, valid MEM_LAT cycles after the strobe.
- load_mem  out  1  word-valid to wrapper.
- location  out  ADDR_W  table index of mem_data.
- mem_data  out  DATA_W  table word to wrapper.
- done_wait  in  1  wrapper table-ready indication.
- src_data  in  8  signed upstream sample.
- src_valid  in  1  upstream sample valid.
- noise_in  out  8  signed sample to wrapper.
- noise_in_valid  out  1  sample valid to wrapper.
- busy  out  1  high in FETCH or WAIT_DONE.
- running  out  1  high in RUN.
- err_timeout  out  1  sticky; cleared by start or reset.

Behaviour:
- Reset: rstn sampled on posedge clk, active low, synchronous.
  - All outputs and counters go to 0; state goes to IDLE.
  - The read-valid pipeline is cleared, so data returning from pre-reset reads is discarded.
  - Reset mid-FETCH or mid-RUN aborts immediately on that edge.
- States: IDLE, FETCH, WAIT_DONE, RUN, ERR.
- Length: len = (cfg_len == 0 || cfg_len > NUM_ENTRIES) ? NUM_ENTRIES : cfg_len, latched on the accepting start edge.
- IDLE:
  - start -> FETCH; clears err_timeout.
  - stop is ignored.
- FETCH, issue side:
  - ocm_rd_en = 1 with ocm_rd_addr = 0, 1, …, len-1 on consecutive cycles.
  - The address counter stops after len-1.
- FETCH, return side:
  - A MEM_LAT-deep valid/index shift register tracks reads in flight.
  - On each return: load_mem = 1 for one cycle, mem_data = ocm_rd_data registered, location = that word's index.
  - load_mem is registered: the first load_mem occurs MEM_LAT+1 cycles after the first ocm_rd_en.
  - Exactly len load_mem pulses, back-to-back, locations 0..len-1, with no gaps and no duplicates.
  - After the last return -> WAIT_DONE.
- FETCH, other inputs:
  - start and stop are ignored.
  - done_wait is ignored.
- WAIT_DONE:
  - load_mem = 0; a timeout counter increments each cycle.
  - done_wait = 1 -> RUN on the next edge.
  - Counter reaches TIMEOUT-1 without done_wait -> ERR and err_timeout = 1.
  - stop -> IDLE.
  - If done_wait and timeout occur on the same cycle, done_wait wins.
- RUN:
  - noise_in and noise_in_valid are registered copies of src_data and src_valid: 1-cycle latency, no backpressure, no drops.
  - stop -> IDLE, with noise_in_valid = 0 from the next cycle.
  - start -> FETCH (reload with a newly latched len); noise_in_valid is forced to 0 throughout FETCH and WAIT_DONE.
  - If start and stop arrive on the same cycle, stop wins.
- ERR:
  - All strobes are 0; err_timeout is held.
  - start -> FETCH (retry, clears the error); stop -> IDLE.
- Output qualifiers:
  - busy = (FETCH || WAIT_DONE); running = RUN.
  - mem_data and location hold their last value when load_mem = 0.

Decomposition:
- Package noise_ctrl_pkg holds:
  - state enum noise_ctrl_state_e {IDLE, FETCH, WAIT_DONE, RUN, ERR};
  - localparams NOISE_BINS = 128 and BINS_PER_WORD = 8;
  - the default NUM_ENTRIES = NOISE_BINS / BINS_PER_WORD.
- One sub-module, noise_rd_pipe: MEM_LAT-deep valid and index delay line, with synchronous clear.

Test Plan:
- Basic load: MEM_LAT = 1, cfg_len = 0, OCM word k = {8{k[3:0], k[3:0]}}, start -> 16 consecutive load_mem pulses, location 0..15, mem_data matches word k; done_wait raised 5 cycles later -> running = 1; src 0x05, 0xFB -> noise_in 0x05, 0xFB one cycle later.
- Latency sweep: MEM_LAT = 3, cfg_len = 4 -> first load_mem exactly 4 cycles after the first ocm_rd_en; exactly 4 pulses; then busy = 1 until done_wait.
- Clamp: cfg_len = 20 -> 16 pulses, last location = 15, ocm_rd_addr never exceeds 15.
- Timeout: TIMEOUT = 8, done_wait held 0 -> ERR after 8 WAIT_DONE cycles, err_timeout = 1; then start -> err_timeout = 0 and a fresh load begins at location 0.
- Reset mid-fetch: rstn = 0 at word 6 of 16 -> all outputs 0 on the next edge; no load_mem after release, even for in-flight reads; start -> reload from location 0.
- Reload and collisions: in RUN, start -> noise_in_valid = 0 and a new 16-word load; start and stop on the same cycle in RUN -> IDLE, no reload.

Source files
------------

// File: rtl/noise_ctrl_pkg.sv
// Shared types and constants for the noise-table load sequencer.
package noise_ctrl_pkg;

  localparam int unsigned NOISE_BINS          = 128;
  localparam int unsigned BINS_PER_WORD       = 8;
  localparam int unsigned NUM_ENTRIES_DEFAULT = NOISE_BINS / BINS_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DONE,
    RUN,
    ERR
  } noise_ctrl_state_e;

endpackage

// File: rtl/noise_rd_pipe.sv
// Delay line tracking OCM reads in flight: valid bit plus table index per stage.
module noise_rd_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      idx_q[0] <= in_idx;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/noise_load_ctrl.sv
// Loads the noise distribution table from OCM into the wrapper, waits for
// table-ready, then forwards the upstream sample stream.
module noise_load_ctrl
  import noise_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_ENTRIES = NUM_ENTRIES_DEFAULT,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_len,
  output logic              ocm_rd_en,
  output logic [ADDR_W-1:0] ocm_rd_addr,
  input  logic [DATA_W-1:0] ocm_rd_data,
  output logic              load_mem,
  output logic [ADDR_W-1:0] location,
  output logic [DATA_W-1:0] mem_data,
  input  logic              done_wait,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  output logic [7:0]        noise_in,
  output logic              noise_in_valid,
  output logic              busy,
  output logic              running,
  output logic              err_timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  noise_ctrl_state_e state_q, state_d;

  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] len_c;
  logic [TMO_W-1:0]  tmo_q;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_idx;
  logic              fetch_entry_c;
  logic              last_ret_c;
  logic              tmo_hit_c;
  logic              pipe_clr_c;

  always_comb begin
    len_c = cfg_len;
    if (cfg_len == '0 || cfg_len > ADDR_W'(NUM_ENTRIES)) len_c = ADDR_W'(NUM_ENTRIES);
  end

  assign last_ret_c = load_mem && (location == len_q - ADDR_W'(1));
  assign tmo_hit_c  = (tmo_q == TMO_W'(TIMEOUT - 1));
  // Only reads issued in FETCH may come back as table words.
  assign pipe_clr_c = (state_q != FETCH);

  noise_rd_pipe #(
    .DEPTH (MEM_LAT),
    .IDX_W (ADDR_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (pipe_clr_c),
    .in_valid  (ocm_rd_en),
    .in_idx    (ocm_rd_addr),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; stop outranks start, done_wait outranks timeout.
  always_comb begin
    state_d       = state_q;
    fetch_entry_c = 1'b0;
    case (state_q)
      IDLE:      if (start) state_d = FETCH;
      FETCH:     if (last_ret_c) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (stop)           state_d = IDLE;
        else if (done_wait) state_d = RUN;
        else if (tmo_hit_c) state_d = ERR;
      end
      RUN, ERR: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = FETCH;
      end
      default:   state_d = IDLE;
    endcase
    if (state_d == FETCH && state_q != FETCH) fetch_entry_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_q          <= '0;
      tmo_q          <= '0;
      ocm_rd_en      <= 1'b0;
      ocm_rd_addr    <= '0;
      load_mem       <= 1'b0;
      location       <= '0;
      mem_data       <= '0;
      noise_in       <= '0;
      noise_in_valid <= 1'b0;
      busy           <= 1'b0;
      running        <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      busy    <= (state_d == FETCH) || (state_d == WAIT_DONE);
      running <= (state_d == RUN);

      // Issue side: one read per cycle, address parks on len-1.
      if (fetch_entry_c) begin
        len_q       <= len_c;
        ocm_rd_en   <= 1'b1;
        ocm_rd_addr <= '0;
      end else if (ocm_rd_en) begin
        if (ocm_rd_addr == len_q - ADDR_W'(1)) ocm_rd_en   <= 1'b0;
        else                                   ocm_rd_addr <= ocm_rd_addr + ADDR_W'(1);
      end

      load_mem <= pipe_valid;
      if (pipe_valid) begin
        mem_data <= ocm_rd_data;
        location <= pipe_idx;
      end

      tmo_q <= (state_q == WAIT_DONE) ? tmo_q + TMO_W'(1) : '0;

      if (fetch_entry_c)                                err_timeout <= 1'b0;
      else if (state_q == WAIT_DONE && state_d == ERR)  err_timeout <= 1'b1;

      if (state_q == RUN && state_d == RUN) begin
        noise_in       <= src_data;
        noise_in_valid <= src_valid;
      end else begin
        noise_in_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noise_load_ctrl.sv
// Directed bench: instance A (MEM_LAT=1, TIMEOUT=8) and instance B (MEM_LAT=3).
module tb_noise_load_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_a, start_b, stop, done_wait, src_valid;
  logic [7:0]  cfg_len, src_data;

  logic        rd_en_a, load_a, niv_a, busy_a, run_a, err_a;
  logic [7:0]  rd_addr_a, loc_a, ni_a;
  logic [63:0] rd_data_a, mem_a;
  logic        rd_en_b, load_b, niv_b, busy_b, run_b, err_b;
  logic [7:0]  rd_addr_b, loc_b, ni_b;
  logic [63:0] rd_data_b, mem_b, pipe1_b, pipe2_b;

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  noise_load_ctrl #(.MEM_LAT(1), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .stop(stop), .cfg_len(cfg_len),
    .ocm_rd_en(rd_en_a), .ocm_rd_addr(rd_addr_a), .ocm_rd_data(rd_data_a),
    .load_mem(load_a), .location(loc_a), .mem_data(mem_a), .done_wait(done_wait),
    .src_data(src_data), .src_valid(src_valid), .noise_in(ni_a), .noise_in_valid(niv_a),
    .busy(busy_a), .running(run_a), .err_timeout(err_a)
  );

  noise_load_ctrl #(.MEM_LAT(3), .TIMEOUT(1024)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .stop(stop), .cfg_len(cfg_len),
    .ocm_rd_en(rd_en_b), .ocm_rd_addr(rd_addr_b), .ocm_rd_data(rd_data_b),
    .load_mem(load_b), .location(loc_b), .mem_data(mem_b), .done_wait(done_wait),
    .src_data(src_data), .src_valid(src_valid), .noise_in(ni_b), .noise_in_valid(niv_b),
    .busy(busy_b), .running(run_b), .err_timeout(err_b)
  );

  function automatic logic [63:0] word_of(input int k);
    logic [3:0] n;
    logic [7:0] b;
    n = 4'(k);
    b = {n, n};
    return {8{b}};
  endfunction

  // OCM models: latency 1 for A, latency 3 for B.
  always @(posedge clk) begin
    rd_data_a <= word_of(int'(rd_addr_a));
    pipe1_b   <= word_of(int'(rd_addr_b));
    pipe2_b   <= pipe1_b;
    rd_data_b <= pipe2_b;
  end

  wire        m_rd_en   = sel ? rd_en_b   : rd_en_a;
  wire [7:0]  m_rd_addr = sel ? rd_addr_b : rd_addr_a;
  wire        m_load    = sel ? load_b    : load_a;
  wire [7:0]  m_loc     = sel ? loc_b     : loc_a;
  wire [63:0] m_mem     = sel ? mem_b     : mem_a;
  wire        m_niv     = sel ? niv_b     : niv_a;
  wire        m_busy    = sel ? busy_b    : busy_a;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] src;
    logic       src_v;
    logic [7:0] exp_ni;
    logic       exp_niv;
    logic       exp_run;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Called at the first FETCH cycle; returns at the first cycle after the last word.
  task automatic fetch_check(input string tag, input int exp_len, input int lat);
    int first_rd = -1, first_ld = -1, n = 0, last = -1, max_addr = 0;
    bit gap = 0, bad_loc = 0, bad_data = 0, bad_niv = 0;
    for (int c = 0; c < 80; c++) begin
      if (m_niv) bad_niv = 1;
      if (m_rd_en) begin
        if (first_rd < 0) first_rd = c;
        if (int'(m_rd_addr) > max_addr) max_addr = int'(m_rd_addr);
      end
      if (m_load) begin
        if (first_ld < 0) first_ld = c;
        else if (c != last + 1) gap = 1;
        if (m_loc != 8'(n)) bad_loc = 1;
        if (m_mem != word_of(n)) bad_data = 1;
        n++;
        last = c;
      end
      if (n == exp_len && c > last) break;
      step();
    end
    check({tag, "_first_rd"}, 64'(first_rd), 64'(0));
    check({tag, "_latency"}, 64'(first_ld - first_rd), 64'(lat + 1));
    check({tag, "_pulses"}, 64'(n), 64'(exp_len));
    check({tag, "_gap"}, 64'(gap), 64'(0));
    check({tag, "_location"}, 64'(bad_loc), 64'(0));
    check({tag, "_data"}, 64'(bad_data), 64'(0));
    check({tag, "_max_addr"}, 64'(max_addr), 64'(exp_len - 1));
    check({tag, "_niv_low"}, 64'(bad_niv), 64'(0));
    check({tag, "_busy_wait"}, 64'(m_busy), 64'(1));
    check({tag, "_rd_idle"}, 64'(m_rd_en), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit flag;

    vecs[0] = '{1'b0, 1'b0, 8'h05, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'hFB, 1'b1, 8'hFB, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h22, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};

    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; stop = 1'b0; done_wait = 1'b0;
    src_valid = 1'b0; src_data = 8'h00; cfg_len = 8'd0;
    repeat (3) step();
    check("rst_rd_en", 64'(rd_en_a), 64'(0));
    check("rst_load", 64'(load_a), 64'(0));
    check("rst_location", 64'(loc_a), 64'(0));
    check("rst_mem_data", mem_a, 64'(0));
    check("rst_busy", 64'({busy_a, busy_b}), 64'(0));
    check("rst_running", 64'({run_a, run_b}), 64'(0));
    check("rst_err", 64'({err_a, err_b}), 64'(0));
    rstn = 1'b1;
    step();

    // Basic load, done_wait five cycles into WAIT_DONE, then the passthrough table.
    pulse_start();
    fetch_check("basic", 16, 1);
    repeat (4) step();
    done_wait = 1'b1;
    step();
    done_wait = 1'b0;
    check("basic_running", 64'(run_a), 64'(1));
    check("basic_busy_run", 64'(busy_a), 64'(0));
    for (int i = 0; i < 6; i++) begin
      start_a = vecs[i].start; stop = vecs[i].stop;
      src_data = vecs[i].src; src_valid = vecs[i].src_v;
      step();
      start_a = 1'b0; stop = 1'b0;
      check($sformatf("vec%0d_noise_in", i), 64'(ni_a), 64'(vecs[i].exp_ni));
      check($sformatf("vec%0d_noise_valid", i), 64'(niv_a), 64'(vecs[i].exp_niv));
      check($sformatf("vec%0d_running", i), 64'(run_a), 64'(vecs[i].exp_run));
      check($sformatf("vec%0d_busy", i), 64'(busy_a), 64'(vecs[i].exp_busy));
    end
    src_valid = 1'b0;

    // Reload from RUN.
    pulse_start();
    fetch_check("pre_reload", 16, 1);
    done_wait = 1'b1;
    step();
    done_wait = 1'b0;
    src_data = 8'h33; src_valid = 1'b1;
    step();
    check("reload_run_valid", 64'(niv_a), 64'(1));
    pulse_start();
    check("reload_valid_drop", 64'(niv_a), 64'(0));
    fetch_check("reload", 16, 1);
    src_valid = 1'b0;
    pulse_stop();
    check("reload_stop_idle", 64'(busy_a), 64'(0));

    // Length clamp.
    cfg_len = 8'd20;
    pulse_start();
    fetch_check("clamp", 16, 1);
    pulse_stop();

    // Timeout and retry.
    cfg_len = 8'd2;
    pulse_start();
    fetch_check("tmo_load", 2, 1);
    cnt = -1;
    for (int c = 0; c < 30; c++) begin
      if (err_a) begin cnt = c; break; end
      step();
    end
    check("tmo_cycles", 64'(cnt), 64'(8));
    check("tmo_err", 64'(err_a), 64'(1));
    check("tmo_busy", 64'(busy_a), 64'(0));
    repeat (3) step();
    check("tmo_sticky", 64'(err_a), 64'(1));
    pulse_start();
    check("tmo_retry_clear", 64'(err_a), 64'(0));
    fetch_check("tmo_retry", 2, 1);
    pulse_stop();

    // Reset in the middle of a fetch.
    cfg_len = 8'd0;
    pulse_start();
    for (int c = 0; c < 30; c++) begin
      if (rd_addr_a == 8'd6) break;
      step();
    end
    check("mid_addr6", 64'(rd_addr_a), 64'(6));
    rstn = 1'b0;
    step();
    check("mid_rst_outs", 64'({rd_en_a, load_a, busy_a, run_a, niv_a}), 64'(0));
    check("mid_rst_addr_loc", 64'({rd_addr_a, loc_a}), 64'(0));
    check("mid_rst_data", mem_a, 64'(0));
    rstn = 1'b1;
    flag = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (load_a) flag = 1'b1;
    end
    check("mid_no_stale_load", 64'(flag), 64'(0));
    pulse_start();
    fetch_check("mid_reload", 16, 1);
    pulse_stop();

    // Read latency 3 on instance B.
    sel = 1'b1;
    cfg_len = 8'd4;
    pulse_start();
    fetch_check("lat3", 4, 3);
    flag = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (!busy_b) flag = 1'b1;
    end
    check("lat3_busy_hold", 64'(flag), 64'(0));
    done_wait = 1'b1;
    step();
    done_wait = 1'b0;
    check("lat3_running", 64'({run_b, busy_b}), 64'(2'b10));
    pulse_stop();
    check("lat3_stop", 64'(run_b), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
